// File: rtl/display_page_sequencer.sv
// Page sequencer for the seven-segment readout: selects one of NUM_PAGES data words
// by button pulses, a next-page pulse or timed auto-rotation, with timeout and freeze.
module display_page_sequencer #(
    parameter int NUM_PAGES      = 4,
    parameter int DATA_W         = 32,
    parameter int DEFAULT_PAGE   = 0,
    parameter int TIMEOUT_CYCLES = 500_000_000,
    parameter int ROTATE_CYCLES  = 200_000_000,
    parameter int PW             = $clog2(NUM_PAGES)
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [NUM_PAGES*DATA_W-1:0] i_page_data,
    input  logic [NUM_PAGES-1:0]        i_sel_req,
    input  logic                        i_next,
    input  logic                        i_auto_rotate,
    input  logic                        i_freeze,
    output logic [DATA_W-1:0]           o_data,
    output logic [PW-1:0]               o_page,
    output logic                        o_frozen,
    output logic                        o_page_change,
    output logic [1:0]                  fsm_state
);

    localparam int MAX_CNT = (TIMEOUT_CYCLES > ROTATE_CYCLES) ? TIMEOUT_CYCLES : ROTATE_CYCLES;
    localparam int CW      = $clog2(MAX_CNT + 1);

    localparam logic [PW-1:0] DEF_PAGE  = PW'(DEFAULT_PAGE);
    localparam logic [PW-1:0] LAST_PAGE = PW'(NUM_PAGES - 1);
    localparam logic [CW-1:0] T_LAST    = (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] R_LAST    = CW'(ROTATE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_DEFAULT = 2'd0,
        ST_MANUAL  = 2'd1,
        ST_ROTATE  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [PW-1:0]   page_n;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_n;
    logic            sel_hit;
    logic [PW-1:0]   sel_idx;
    logic [PW-1:0]   page_inc;
    logic [DATA_W-1:0] pages [NUM_PAGES];

    for (genvar k = 0; k < NUM_PAGES; k++) begin : g_unpack
        assign pages[k] = i_page_data[k*DATA_W +: DATA_W];
    end

    // Descending scan so the lowest set request bit is the one that sticks.
    always_comb begin
        sel_hit = 1'b0;
        sel_idx = '0;
        for (int k = NUM_PAGES - 1; k >= 0; k--) begin
            if (i_sel_req[k]) begin
                sel_hit = 1'b1;
                sel_idx = PW'(k);
            end
        end
    end

    assign page_inc = (o_page == LAST_PAGE) ? '0 : o_page + PW'(1);

    // One counter serves both modes: it is the idle count in MANUAL and the dwell count in ROTATE.
    always_comb begin
        state_n = state;
        page_n  = o_page;
        cnt_n   = cnt;
        if (sel_hit) begin
            state_n = ST_MANUAL;
            page_n  = sel_idx;
            cnt_n   = '0;
        end else if (i_next) begin
            state_n = ST_MANUAL;
            page_n  = page_inc;
            cnt_n   = '0;
        end else begin
            case (state)
                ST_DEFAULT: begin
                    if (i_auto_rotate) begin
                        state_n = ST_ROTATE;
                        cnt_n   = '0;
                    end
                end
                ST_MANUAL: begin
                    if (i_auto_rotate) begin
                        state_n = ST_ROTATE;
                        cnt_n   = '0;
                    end else if (TIMEOUT_CYCLES != 0) begin
                        if (cnt == T_LAST) begin
                            state_n = ST_DEFAULT;
                            page_n  = DEF_PAGE;
                            cnt_n   = '0;
                        end else begin
                            cnt_n = cnt + CW'(1);
                        end
                    end
                end
                ST_ROTATE: begin
                    if (!i_auto_rotate) begin
                        state_n = ST_DEFAULT;
                        page_n  = DEF_PAGE;
                        cnt_n   = '0;
                    end else if (cnt == R_LAST) begin
                        page_n = page_inc;
                        cnt_n  = '0;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                default: begin
                    state_n = ST_DEFAULT;
                    page_n  = DEF_PAGE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state         <= ST_DEFAULT;
            o_page        <= DEF_PAGE;
            cnt           <= '0;
            o_data        <= '0;
            o_frozen      <= 1'b0;
            o_page_change <= 1'b0;
        end else begin
            state         <= state_n;
            o_page        <= page_n;
            cnt           <= cnt_n;
            o_frozen      <= i_freeze;
            o_page_change <= (page_n != o_page);
            // Data follows the page being entered so a selection shows with one cycle of latency.
            if (!i_freeze) begin
                o_data <= pages[page_n];
            end
        end
    end

    assign fsm_state = state;

endmodule

// File: doc/display_page_sequencer.md
# display_page_sequencer

Parametrised page sequencer for the board's seven-segment readout. It generalises the fixed result/instruction/flags/max-address display selection to NUM_PAGES data pages of DATA_W bits. Pages are chosen by one-cycle request pulses from the debounced buttons, by a "next page" pulse, or by timed auto-rotation. Manual selections fall back to a default page after a timeout, and a freeze input holds the displayed value. It sits between the CPU status outputs and the seven-segment driver.

## Interface
- NUM_PAGES, 4: number of pages; must be ≥ 2. Need not be a power of two.
- DATA_W, 32: width of each page.
- DEFAULT_PAGE, 0: page shown after reset and after a timeout; must be < NUM_PAGES.
- TIMEOUT_CYCLES, 500_000_000: cycles a manual selection is held with no request before reverting. 0 disables the timeout.
- ROTATE_CYCLES, 200_000_000: dwell cycles per page in rotate mode; must be ≥ 1.
- PW (derived): $clog2(NUM_PAGES).

Ports:
- i_clk  in  1  system clock, 100 MHz.
- i_rst  in  1  asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- i_page_data  in  NUM_PAGES*DATA_W  flattened page data; page k is [k*DATA_W +: DATA_W].
- i_sel_req  in  NUM_PAGES  one-cycle select pulses; bit k requests page k.
- i_next  in  1  one-cycle pulse; advance to the next page.
- i_auto_rotate  in  1  level; enables rotate mode.
- i_freeze  in  1  level; holds o_data.
- o_data  out  DATA_W  registered display word.
- o_page  out  PW  current page index.
- o_frozen  out  1  registered copy of i_freeze.
- o_page_change  out  1  one-cycle pulse when o_page changes.

## Operation
State machine states: DEFAULT, MANUAL, ROTATE.

Event priority per cycle, highest first:
1. i_sel_req
2. i_next
3. rotate/timeout logic

i_sel_req:
- If multiple bits are set, the lowest set index wins.
- Sets page_next = index and moves to MANUAL from any state.
- Restarts the timeout counter.

i_next:
- page_next = (o_page == NUM_PAGES-1) ? 0 : o_page+1.
- Moves to MANUAL from any state and restarts the timeout counter.

DEFAULT:
- o_page = DEFAULT_PAGE.
- i_auto_rotate high → ROTATE. The rotate counter clears and the page is unchanged on entry.

MANUAL:
- The timeout counter increments each cycle with no request.
- When the counter reaches TIMEOUT_CYCLES-1 → DEFAULT, page_next = DEFAULT_PAGE, counter cleared.
- With TIMEOUT_CYCLES = 0, MANUAL persists until another event occurs.
- i_auto_rotate high with no request in the same cycle → ROTATE.

ROTATE:
- The rotate counter reaches ROTATE_CYCLES-1 → advance with wrap, counter cleared.
- i_auto_rotate low → DEFAULT, page_next = DEFAULT_PAGE.
- A manual request overrides and moves to MANUAL. Rotation does not resume until i_auto_rotate is seen high again from DEFAULT or MANUAL.

Requesting the page already shown:
- Restarts the timeout.
- Does not pulse o_page_change.

Freeze:
- While i_freeze is high, o_data holds its value.
- o_page and the FSM keep operating underneath.
- When i_freeze falls, o_data tracks the current page again from the next edge.

Counter widths:
- $clog2(max(TIMEOUT_CYCLES, ROTATE_CYCLES)+1).
- No overflow is possible; counters clear at their terminal value.

## Timing
- Reset values (asserted asynchronously): o_page = DEFAULT_PAGE, o_data = 0, o_frozen = 0, o_page_change = 0, state DEFAULT, counters 0.
- First edge after reset release: o_data = page DEFAULT_PAGE data.
- Request sampled at edge t: o_page = new index after edge t. o_data = i_page_data[new page] sampled at edge t. This gives 1-cycle latency.
- o_page_change is high for exactly the cycle after the edge on which o_page changed.
- o_data is otherwise re-sampled every cycle from the current page, so live CPU values update continuously.
- o_frozen is registered, so it lags i_freeze by 1 cycle. o_data holds from the edge on which i_freeze is sampled high.
- Timeout: last request at edge t → revert at edge t+TIMEOUT_CYCLES.
- Rotate: the page advances every ROTATE_CYCLES edges.
- Reset asserted mid-timeout or mid-rotation: all state clears immediately and no pulse is emitted.

## Test plan
Bench parameters: NUM_PAGES=4, DATA_W=32, DEFAULT_PAGE=0, TIMEOUT_CYCLES=8, ROTATE_CYCLES=4. Page k data = 32'hA000_000k.

1. Reset release, then i_sel_req=4'b0100 → o_page 2 and o_data 32'hA000_0002 one cycle later, o_page_change pulses once. After 8 idle cycles → o_page 0 with o_page_change pulse.
2. i_sel_req=4'b1010 → page 1 (lowest index) selected. Same cycle with i_next=1 → i_next ignored, o_page = 1.
3. i_next pulsed 5 times from page 0 → o_page 1,2,3,0,1. Repeat with NUM_PAGES=3 → wrap 2→0.
4. i_auto_rotate=1 for 20 cycles → o_page advances every 4 cycles 0→1→2→3→0. Drop i_auto_rotate → o_page 0 the next cycle.
5. Page 1 shown, i_freeze=1, page data changed to 32'hDEAD_BEEF and i_next pulsed → o_data stays 32'hA000_0001, o_page = 2. Release freeze → o_data = page 2 data next cycle.
6. i_rst asserted mid-timeout in MANUAL on page 3 → outputs reach reset values without waiting for a clock edge. After release, no timeout pulse fires and o_page stays 0.
